spi_slave_uc: RTL and testbench
===============================

// Module: spi_slave_uc
// PURPOSE
//  SPI slave (responder), mode 0 (CPOL=0, CPHA=0), MSB first; the other end of the team's SPI_MASTER_UC link.
//  Oversamples SCK/CSbar/MOSI in the SYS_CLK domain, deserialises MOSI words and serialises a TX word on MISO.
//  Sits between the external SPI pins and FPGA register/control logic; one word = outBits bits.
// PARAMETERS
//  outBits   16   word width in bits (2..32)
// PORTS
//  SYS_CLK     in   1        system clock; all logic on posedge
//  RST         in   1        synchronous, active-high reset
//  SCK         in   1        SPI clock from master (async); f_SCK <= f_SYS_CLK/8
//  CSbar       in   1        chip select, active low (async)
//  MOSI        in   1        master-out serial data (async)
//  MISO        out  1        slave-out serial data
//  MISO_OE     out  1        MISO pad enable; 1 while frame active
//  DATA_TX     in   outBits  word to transmit; sampled at frame start and each word boundary
//  TX_LOAD     out  1        1-cycle pulse when DATA_TX is sampled
//  DATA_RX     out  outBits  last complete received word (held)
//  DATA_VALID  out  1        1-cycle pulse: DATA_RX updated
//  BUSY        out  1        1 while in SHIFT
//  OVERRUN     out  1        sticky overrun flag (SPI_SLAVE_OVERRUN_EN only; else tied 0)
//  RX_ACK      in   1        consumer ack of DATA_RX (SPI_SLAVE_OVERRUN_EN only; ignored otherwise)
// BEHAVIOUR
//  Reset (RST=1 at posedge): all outputs 0, counters 0, shift regs 0, state WAIT_CS_HIGH.
//  Inputs pass 2-FF synchronisers; edges detected on synced SCK/CSbar (latency 3 SYS_CLK from pin).
//  FSM: WAIT_CS_HIGH -> IDLE when synced CSbar=1 (reset mid-frame never joins a frame in progress).
//       IDLE -> SHIFT on synced CSbar fall: load tx_sr<=DATA_TX, TX_LOAD=1, bit_cnt<=0, MISO<=DATA_TX[MSB], MISO_OE<=1.
//       SHIFT -> IDLE on synced CSbar rise (any bit_cnt): MISO_OE<=0, MISO<=0; partial word discarded, no DATA_VALID.
//  SHIFT, SCK rise: rx_sr <= {rx_sr[outBits-2:0], MOSI_sync}; bit_cnt++.
//  SHIFT, SCK fall: tx_sr shift left, MISO <= next bit; MISO stable whole SCK high phase.
//  Word complete (bit_cnt reaches outBits on SCK rise): next cycle DATA_RX<=assembled word, DATA_VALID=1,
//    bit_cnt wraps to 0, tx_sr<=DATA_TX with TX_LOAD=1, MISO<=new MSB on following SCK fall (multi-word frames).
//  CSbar rise on same cycle as word-completing SCK rise: word is delivered (DATA_VALID=1), then IDLE.
//  SCK edges while not SHIFT ignored. bit_cnt width $clog2(outBits+1). DATA_RX holds until next complete word.
// CONFIGURATION
//  `SPI_SLAVE_OVERRUN_EN defined: rx_pending set on DATA_VALID, cleared by RX_ACK (ACK wins if same cycle as
//    no new word; new word wins over ACK). DATA_VALID while rx_pending=1 -> OVERRUN<=1 (sticky until RST),
//    DATA_RX still overwritten.
//  Not defined: no rx_pending logic; OVERRUN driven 0, RX_ACK unused.
// STRUCTURE
//  Package spi_uc_pkg: default word width, FSM state encoding (WAIT_CS_HIGH, IDLE, SHIFT), SPI mode constants.
//  Sub-module spi_sync_edge: 2-FF sync + rise/fall pulse outputs; instanced for SCK and CSbar (MOSI uses sync only).
// TESTING
//  1 RST during frame, CSbar low after release, 8 SCK -> no DATA_VALID until CSbar high then low again.
//  2 Frame MOSI=0xA5C3, DATA_TX=0x3C5A, 16 SCK at SYS_CLK/8 -> DATA_RX=0xA5C3, 1 DATA_VALID, MISO bits = 0x3C5A.
//  3 32-bit frame MOSI 0x1234,0xBEEF; DATA_TX changes 0x1111->0x2222 mid word 1 -> 2 pulses, MISO=0x1111,0x2222.
//  4 CSbar rises after 9 bits -> no DATA_VALID, DATA_RX keeps prior 0xA5C3, MISO_OE=0, BUSY=0.
//  5 OVERRUN_EN: two words no RX_ACK -> OVERRUN=1 after 2nd; with RX_ACK between -> OVERRUN stays 0.
//  6 SCK toggling with CSbar high -> no DATA_VALID, TX_LOAD, or MISO_OE.

Source files
------------

// File: rtl/spi_uc_pkg.sv
// spi_uc_pkg: shared word width, FSM state encoding and SPI mode constants for the SPI slave.
package spi_uc_pkg;
    localparam int DEF_OUT_BITS = 16;
    typedef logic [1:0] state_t;
    localparam state_t ST_WAIT_CS_HIGH = 2'd0;
    localparam state_t ST_IDLE         = 2'd1;
    localparam state_t ST_SHIFT        = 2'd2;
    localparam logic SPI_CPOL = 1'b0;
    localparam logic SPI_CPHA = 1'b0;
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: 2-FF synchroniser for an asynchronous pin plus one-cycle rise/fall pulses.
module spi_sync_edge (
    input  logic SYS_CLK,
    input  logic RST,
    input  logic i_d,
    output logic o_q,
    output logic o_rise,
    output logic o_fall
);
    logic r_s1, r_s2, r_s3;
    always_ff @(posedge SYS_CLK) begin
        if (RST) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= i_d;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end
    assign o_q    = r_s2;
    assign o_rise = r_s2 & ~r_s3;
    assign o_fall = ~r_s2 & r_s3;
endmodule

// File: rtl/spi_slave_uc.sv
// spi_slave_uc: mode-0 MSB-first SPI slave, oversampled in the SYS_CLK domain.
// Optional sticky overrun detection with `SPI_SLAVE_OVERRUN_EN.
module spi_slave_uc
    import spi_uc_pkg::*;
#(
    parameter int outBits = DEF_OUT_BITS
) (
    input  logic               SYS_CLK,
    input  logic               RST,
    input  logic               SCK,
    input  logic               CSbar,
    input  logic               MOSI,
    output logic               MISO,
    output logic               MISO_OE,
    input  logic [outBits-1:0] DATA_TX,
    output logic               TX_LOAD,
    output logic [outBits-1:0] DATA_RX,
    output logic               DATA_VALID,
    output logic               BUSY,
    output logic               OVERRUN,
    input  logic               RX_ACK
);
    localparam int CW = $clog2(outBits + 1);
    logic w_unused_sck, w_sck_rise, w_sck_fall;
    logic w_cs, w_cs_rise, w_cs_fall, w_done;
    logic r_mosi1, r_mosi2;
    state_t r_state;
    logic [CW-1:0] r_bit_cnt;
    logic [outBits-1:0] r_rx_sr, r_tx_sr;

    spi_sync_edge u_sck (
        .SYS_CLK(SYS_CLK), .RST(RST), .i_d(SCK),
        .o_q(w_unused_sck), .o_rise(w_sck_rise), .o_fall(w_sck_fall)
    );
    spi_sync_edge u_cs (
        .SYS_CLK(SYS_CLK), .RST(RST), .i_d(CSbar),
        .o_q(w_cs), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
    );

    always_ff @(posedge SYS_CLK) begin
        if (RST) begin
            r_mosi1 <= 1'b0;
            r_mosi2 <= 1'b0;
        end else begin
            r_mosi1 <= MOSI;
            r_mosi2 <= r_mosi1;
        end
    end

    assign w_done = r_bit_cnt == CW'(outBits);
    assign BUSY   = r_state == ST_SHIFT;

    // r_tx_sr holds the bits still to be driven after the current MISO bit.
    always_ff @(posedge SYS_CLK) begin
        if (RST) begin
            r_state    <= ST_WAIT_CS_HIGH;
            r_bit_cnt  <= '0;
            r_rx_sr    <= '0;
            r_tx_sr    <= '0;
            MISO       <= 1'b0;
            MISO_OE    <= 1'b0;
            TX_LOAD    <= 1'b0;
            DATA_RX    <= '0;
            DATA_VALID <= 1'b0;
        end else begin
            TX_LOAD    <= 1'b0;
            DATA_VALID <= 1'b0;
            if (w_done) begin
                DATA_RX    <= r_rx_sr;
                DATA_VALID <= 1'b1;
                r_bit_cnt  <= '0;
            end
            case (r_state)
                ST_WAIT_CS_HIGH: if (w_cs) r_state <= ST_IDLE;
                ST_IDLE: if (w_cs_fall) begin
                    r_state   <= ST_SHIFT;
                    r_tx_sr   <= DATA_TX << 1;
                    TX_LOAD   <= 1'b1;
                    r_bit_cnt <= '0;
                    MISO      <= DATA_TX[outBits-1];
                    MISO_OE   <= 1'b1;
                end
                ST_SHIFT: begin
                    if (w_done) begin
                        r_tx_sr <= DATA_TX;
                        TX_LOAD <= 1'b1;
                    end
                    if (w_sck_rise) begin
                        r_rx_sr   <= {r_rx_sr[outBits-2:0], r_mosi2};
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                    if (w_sck_fall) begin
                        MISO    <= r_tx_sr[outBits-1];
                        r_tx_sr <= r_tx_sr << 1;
                    end
                    if (w_cs_rise) begin
                        r_state <= ST_IDLE;
                        MISO_OE <= 1'b0;
                        MISO    <= 1'b0;
                    end
                end
                default: r_state <= ST_WAIT_CS_HIGH;
            endcase
        end
    end

`ifdef SPI_SLAVE_OVERRUN_EN
    logic r_pending, r_overrun;
    always_ff @(posedge SYS_CLK) begin
        if (RST) begin
            r_pending <= 1'b0;
            r_overrun <= 1'b0;
        end else if (DATA_VALID) begin
            r_pending <= 1'b1;
            if (r_pending) r_overrun <= 1'b1;
        end else if (RX_ACK) begin
            r_pending <= 1'b0;
        end
    end
    assign OVERRUN = r_overrun;
`else
    logic w_unused_ack;
    assign w_unused_ack = RX_ACK;
    assign OVERRUN      = 1'b0;
`endif
endmodule

// File: tb/tb_spi_slave_uc.sv
// tb_spi_slave_uc: table, directed and random frame checks for spi_slave_uc (16-bit words).
module tb_spi_slave_uc;
    logic SYS_CLK = 0, RST = 1, SCK = 0, CSbar = 1, MOSI = 0, RX_ACK = 0;
    logic [15:0] DATA_TX = '0;
    logic MISO, MISO_OE, TX_LOAD, DATA_VALID, BUSY, OVERRUN;
    logic [15:0] DATA_RX;
    int total = 0, bad = 0, lc = 0;
    logic [15:0] vq[$];
    logic [15:0] mw[9], tw[9], gm[9];

    spi_slave_uc dut (
        .SYS_CLK(SYS_CLK), .RST(RST), .SCK(SCK), .CSbar(CSbar), .MOSI(MOSI),
        .MISO(MISO), .MISO_OE(MISO_OE), .DATA_TX(DATA_TX), .TX_LOAD(TX_LOAD),
        .DATA_RX(DATA_RX), .DATA_VALID(DATA_VALID), .BUSY(BUSY),
        .OVERRUN(OVERRUN), .RX_ACK(RX_ACK)
    );

    always #5 SYS_CLK = ~SYS_CLK;

    always @(negedge SYS_CLK) begin
        if (!RST && DATA_VALID) vq.push_back(DATA_RX);
        if (!RST && TX_LOAD) lc++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(posedge SYS_CLK);
        #1;
    endtask

    // Master model: SCK at SYS_CLK/8, MOSI set while SCK low, MISO sampled just before each rise.
    task automatic frame(input int nbits, input bit cs_with_last);
        DATA_TX = tw[0];
        CSbar = 0;
        clks(4);
        for (int b = 0; b < nbits; b++) begin
            MOSI = mw[b / 16][15 - b % 16];
            clks(4);
            gm[b / 16][15 - b % 16] = MISO;
            SCK = 1;
            if (cs_with_last && b == nbits - 1) CSbar = 1;
            if (b % 16 == 8) DATA_TX = tw[b / 16 + 1];
            clks(4);
            SCK = 0;
        end
        clks(4);
        CSbar = 1;
        MOSI = 0;
        clks(8);
    endtask

    task automatic clear_mon();
        vq.delete();
        lc = 0;
    endtask

    typedef struct {
        logic [15:0] mosi, tx, exp_rx, exp_miso;
    } vec_t;
    vec_t tbl[4];

    initial begin
        tbl[0] = '{16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000};
        tbl[1] = '{16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF};
        tbl[2] = '{16'h8001, 16'h7FFE, 16'h8001, 16'h7FFE};
        tbl[3] = '{16'hA5C3, 16'h3C5A, 16'hA5C3, 16'h3C5A};
        clks(3);
        chk("rst_outs", {MISO, MISO_OE, TX_LOAD, DATA_VALID, BUSY, OVERRUN}, 6'b0);
        chk("rst_rx", DATA_RX, 16'h0);
        // Reset during an active frame must not join it.
        RST = 0;
        clks(5);
        CSbar = 0;
        clks(5);
        RST = 1;
        clks(2);
        RST = 0;
        clear_mon();
        for (int i = 0; i < 8; i++) begin
            MOSI = i[0];
            clks(4); SCK = 1; clks(4); SCK = 0;
        end
        clks(6);
        chk("midrst_valid", vq.size(), 0);
        chk("midrst_load", lc, 0);
        chk("midrst_oe_busy", {MISO_OE, BUSY}, 2'b00);
        CSbar = 1;
        clks(8);
        for (int i = 0; i < 4; i++) begin
            clear_mon();
            mw[0] = tbl[i].mosi; tw[0] = tbl[i].tx; tw[1] = 16'h0;
            frame(16, 0);
            chk($sformatf("tbl%0d_cnt", i), vq.size(), 1);
            chk($sformatf("tbl%0d_rx", i), DATA_RX, tbl[i].exp_rx);
            chk($sformatf("tbl%0d_miso", i), gm[0], tbl[i].exp_miso);
        end
        chk("idle_oe_busy", {MISO_OE, BUSY, MISO}, 3'b000);
        // Frame aborted after 9 bits.
        clear_mon();
        mw[0] = 16'hFFFF; tw[0] = 16'h1357; tw[1] = 16'h0;
        frame(9, 0);
        chk("abort_valid", vq.size(), 0);
        chk("abort_rx", DATA_RX, 16'hA5C3);
        chk("abort_oe_busy", {MISO_OE, BUSY}, 2'b00);
        // Two-word frame with DATA_TX changing mid word 1.
        clear_mon();
        mw[0] = 16'h1234; mw[1] = 16'hBEEF;
        tw[0] = 16'h1111; tw[1] = 16'h2222; tw[2] = 16'h0;
        frame(32, 0);
        chk("w2_cnt", vq.size(), 2);
        chk("w2_rx0", vq.size() > 0 ? vq[0] : 16'hxxxx, 16'h1234);
        chk("w2_rx1", vq.size() > 1 ? vq[1] : 16'hxxxx, 16'hBEEF);
        chk("w2_miso", {gm[0], gm[1]}, 32'h1111_2222);
        chk("w2_loads", lc, 3);
        // Chip select held low with no SCK.
        clear_mon();
        DATA_TX = 16'h8000;
        CSbar = 0;
        clks(6);
        chk("sel_busy_oe_miso", {BUSY, MISO_OE, MISO}, 3'b111);
        chk("sel_load", lc, 1);
        CSbar = 1;
        clks(6);
        // SCK toggling while deselected.
        clear_mon();
        for (int i = 0; i < 10; i++) begin
            MOSI = ~MOSI; clks(4); SCK = 1; clks(4); SCK = 0;
        end
        chk("desel_valid", vq.size(), 0);
        chk("desel_load", lc, 0);
        chk("desel_oe", MISO_OE, 1'b0);
        // CSbar rises together with the word-completing SCK rise.
        clear_mon();
        mw[0] = 16'h5A0F; tw[0] = 16'hC001; tw[1] = 16'h0;
        frame(16, 1);
        chk("edge_cnt", vq.size(), 1);
        chk("edge_rx", DATA_RX, 16'h5A0F);
        chk("edge_busy", BUSY, 1'b0);
        // Random multi-word frames against the word-level model.
        for (int it = 0; it < 20; it++) begin
            int nw;
            nw = $urandom_range(1, 3);
            for (int w = 0; w <= nw; w++) begin
                mw[w] = 16'($urandom);
                tw[w] = 16'($urandom);
            end
            clear_mon();
            frame(16 * nw, 0);
            chk($sformatf("rnd%0d_cnt", it), vq.size(), nw);
            chk($sformatf("rnd%0d_loads", it), lc, nw + 1);
            for (int w = 0; w < nw; w++) begin
                chk($sformatf("rnd%0d_rx%0d", it, w), w < vq.size() ? vq[w] : 16'hxxxx, mw[w]);
                chk($sformatf("rnd%0d_miso%0d", it, w), gm[w], tw[w]);
            end
        end
`ifdef SPI_SLAVE_OVERRUN_EN
        RST = 1; clks(2); RST = 0; clks(8);
        mw[0] = 16'h0F0F; tw[0] = 16'h0; tw[1] = 16'h0;
        frame(16, 0);
        chk("ovr_first", OVERRUN, 1'b0);
        frame(16, 0);
        chk("ovr_second", OVERRUN, 1'b1);
        RST = 1; clks(2); RST = 0; clks(8);
        frame(16, 0);
        RX_ACK = 1; clks(1); RX_ACK = 0;
        frame(16, 0);
        chk("ovr_acked", OVERRUN, 1'b0);
        frame(16, 0);
        chk("ovr_unacked", OVERRUN, 1'b1);
`else
        chk("ovr_tied", OVERRUN, 1'b0);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
